i2c_master_core: RTL and testbench
==================================

# i2c_master_core

Single-byte I2C master engine driving the open-drain `scl`/`sda` pins. It consumes the setup and TX data fields of the GPMC-mapped I2C register block: enable, rw, slave address, write data and fast-mode. It returns busy, ack_error and read data, which the register block mirrors into its read-only bits. One enable rising edge runs exactly one transaction: START, address+R/W, one data byte, STOP.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `STD_RATE`, 100_000, SCL rate in Hz when `fast_mode`=0.
- `FAST_RATE`, 400_000, SCL rate in Hz when `fast_mode`=1.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: asynchronous, active-low reset. The top drives it from the inverted setup reset bit.
- `enable` in 1: a rising edge while idle starts a transaction.
- `addr` in 7: slave address.
- `rw` in 1: 0 = write, 1 = read.
- `data_wr` in 8: byte to write.
- `fast_mode` in 1: selects `FAST_RATE`.
- `busy` out 1: transaction in progress.
- `ack_error` out 1: the slave NACKed the last transaction.
- `data_rd` out 8: last byte read.
- `scl` inout 1: open-drain. Drives 0 or Z.
- `sda` inout 1: open-drain. Drives 0 or Z.

## Operation
- Quarter period Q = CLK_FREQ / (4 × rate), integer division. At the defaults: Q = 250 (standard) and Q = 62 (fast).
- `fast_mode`, `addr`, `rw` and `data_wr` are latched on the start cycle. Changing them mid-transaction has no effect.
- `enable` is registered internally. A start occurs only on a 0→1 edge seen in IDLE. A held-high `enable` does not retrigger.
- The pins are never driven high. A released line reads back 1 through the external pull-up.
- State machine: IDLE → START → ADDR → ADDR_ACK → DATA → DATA_ACK → STOP → IDLE.
- Each state except IDLE lasts 4 quarters, q0..q3. ADDR and DATA each repeat their quarters for 8 bits, MSB first.
- START: q0–q1 release SCL and SDA; q2 pull SDA low with SCL high; q3 pull SCL low.
- Bit states (ADDR, ADDR_ACK, DATA, DATA_ACK), per bit:
  - q0: SCL low; set SDA.
  - q1–q2: SCL released.
  - q3: SCL low.
- The sample point is the first cycle of q2.
- ADDR shifts out {addr, rw}.
- ADDR_ACK releases SDA and samples. A sampled 1 sets `ack_error` and jumps straight to STOP, skipping DATA.
- DATA, write: shifts out `data_wr`.
- DATA, read: releases SDA, shifts in the sampled bits, and loads `data_rd` at the end of bit 0.
- DATA_ACK, write: samples the slave ACK. A sampled 1 sets `ack_error`.
- DATA_ACK, read: the master sends NACK by releasing SDA.
- STOP: q0 SDA low, SCL low; q1 SCL released; q2 SDA released; q3 idle. Then IDLE.
- Clock stretching: in q1, if SCL reads 0 while released, the quarter counter holds until SCL reads 1.
- `ack_error` clears on the start cycle of the next transaction. `data_rd` holds until it is overwritten by a read.

## Timing
- Reset values: `busy`=0, `ack_error`=0, `data_rd`=8'h00, SCL and SDA released, state IDLE.
- Reset asserted mid-transaction releases both lines immediately. No STOP is generated.
- Start latency: `busy` rises 2 cycles after the `enable` rising edge (1 cycle to register the edge, 1 cycle to start).
- Full transaction with no stretching: `busy` stays high for exactly 80·Q cycles (START 4 + ADDR/ACK 36 + DATA/ACK 36 + STOP 4 quarters).
- Address NACK: `busy` is high for 44·Q cycles.
- `ack_error` and `data_rd` are valid on the cycle `busy` falls.
- An `enable` edge while `busy`=1 is ignored.
- Stretching extends `busy` by exactly the number of stalled cycles.

## Structure
- Package `i2c_pkg` holds:
  - the state enum;
  - the quarter-count function Q(CLK_FREQ, rate);
  - the quarter index width.
- Sub-module `i2c_quarter_tick`: a down-counter that is reloaded with Q and emits a 1-cycle tick plus a 2-bit quarter index. It has a `stall` input used for clock stretching, and is restarted by the FSM on the start cycle.
- The FSM, shift register, bit counter and pin drivers live in `i2c_master_core`.

## Test plan
- Write, standard mode: addr=7'h50, data_wr=8'hA5, model ACKs.
  - SDA shows A0, then A5, MSB first, stable while SCL high.
  - `busy` high for 20000 cycles; `ack_error`=0.
- Read, fast mode: addr=7'h48, model returns 8'h3C.
  - Master NACKs the data byte; `data_rd`=8'h3C.
  - `busy` high for 4960 cycles.
- Address NACK: no device present.
  - `ack_error`=1; DATA is skipped; STOP is generated.
  - `busy` high for 44·Q cycles.
  - The next transaction clears `ack_error` on its start cycle.
- Clock stretch: model holds SCL low for 1000 cycles in bit 3 of DATA.
  - `busy` is extended by exactly 1000 cycles.
  - Data is correct.
- Edge behaviour: `enable` held high after completion, then pulsed during `busy`.
  - No second transaction occurs in either case.
- Reset mid-DATA: both lines are released within 1 cycle; `busy`=0.
  - After reset release, a new `enable` edge completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state type, widths and quarter-period helper for the I2C master
package i2c_pkg;

    localparam int QIDX_W = 2;
    localparam int QCNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } i2c_state_e;

    function automatic int quarter_count(input int clk_freq, input int rate);
        return clk_freq / (4 * rate);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter-period down-counter with stall, tick and quarter index
module i2c_quarter_tick
    import i2c_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart_i,
    input  logic              stall_i,
    input  logic [QCNT_W-1:0] load_i,
    output logic              tick_o,
    output logic              first_o,
    output logic [QIDX_W-1:0] qtr_o
);

    logic [QCNT_W-1:0] cnt_q, cnt_d;
    logic [QIDX_W-1:0] qtr_q, qtr_d;
    logic              first_q, first_d;

    always_comb begin
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        first_d = 1'b0;
        tick_o  = 1'b0;
        if (restart_i) begin
            cnt_d   = load_i - QCNT_W'(1);
            qtr_d   = '0;
            first_d = 1'b1;
        end else if (!stall_i) begin
            if (cnt_q == '0) begin
                tick_o  = 1'b1;
                cnt_d   = load_i - QCNT_W'(1);
                qtr_d   = qtr_q + QIDX_W'(1);
                first_d = 1'b1;
            end else begin
                cnt_d = cnt_q - QCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            qtr_q   <= '0;
            first_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            first_q <= first_d;
        end
    end

    assign qtr_o   = qtr_q;
    assign first_o = first_q;

endmodule

// File: rtl/i2c_master_core.sv
// rtl/i2c_master_core.sv - single-byte I2C master: START, addr+R/W, one data byte, STOP
module i2c_master_core
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int STD_RATE  = 100_000,
    parameter int FAST_RATE = 400_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    input  logic       fast_mode,
    output logic       busy,
    output logic       ack_error,
    output logic [7:0] data_rd,
    inout  wire        scl,
    inout  wire        sda
);

    localparam logic [QCNT_W-1:0] Q_STD  = QCNT_W'(quarter_count(CLK_FREQ, STD_RATE));
    localparam logic [QCNT_W-1:0] Q_FAST = QCNT_W'(quarter_count(CLK_FREQ, FAST_RATE));

    i2c_state_e        state_q, state_d;
    logic              en_q, en_prev_q;
    logic              rw_q, fast_q, ack_err_q;
    logic [7:0]        data_q, shift_q, data_rd_q;
    logic [2:0]        bit_q;
    logic              scl_low, sda_low;
    logic              start, last, sample, stall, tick, first;
    logic [QIDX_W-1:0] qtr;
    logic [QCNT_W-1:0] load;

    assign start  = (state_q == ST_IDLE) && en_q && !en_prev_q;
    assign last   = tick && (qtr == 2'd3);
    assign sample = first && (qtr == 2'd2);
    // SCL is released in every q1, so a low readback there is the slave stretching
    assign stall  = (state_q != ST_IDLE) && (qtr == 2'd1) && (scl == 1'b0);
    assign load   = ((state_q == ST_IDLE) ? fast_mode : fast_q) ? Q_FAST : Q_STD;

    i2c_quarter_tick u_tick (
        .clk       (clk),
        .rst_n     (rst),
        .restart_i (start),
        .stall_i   (stall),
        .load_i    (load),
        .tick_o    (tick),
        .first_o   (first),
        .qtr_o     (qtr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_START;
            ST_START: begin
                sda_low = qtr[1];
                scl_low = (qtr == 2'd3);
                if (last) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                sda_low = !shift_q[7];
                if (last && bit_q == 3'd0) state_d = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                if (last) state_d = ack_err_q ? ST_STOP : ST_DATA;
            end
            ST_DATA: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                sda_low = !rw_q && !shift_q[7];
                if (last && bit_q == 3'd0) state_d = ST_DATA_ACK;
            end
            ST_DATA_ACK: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                if (last) state_d = ST_STOP;
            end
            ST_STOP: begin
                scl_low = (qtr == 2'd0);
                sda_low = (qtr <= 2'd1);
                if (last) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            rw_q      <= 1'b0;
            fast_q    <= 1'b0;
            ack_err_q <= 1'b0;
            data_q    <= '0;
            shift_q   <= '0;
            data_rd_q <= '0;
            bit_q     <= '0;
        end else begin
            en_q      <= enable;
            en_prev_q <= en_q;
            if (start) begin
                shift_q   <= {addr, rw};
                rw_q      <= rw;
                data_q    <= data_wr;
                fast_q    <= fast_mode;
                bit_q     <= 3'd7;
                ack_err_q <= 1'b0;
            end else begin
                if (sample) begin
                    if ((state_q == ST_ADDR_ACK || (state_q == ST_DATA_ACK && !rw_q)) && sda == 1'b1)
                        ack_err_q <= 1'b1;
                    if (state_q == ST_DATA && rw_q)
                        shift_q <= {shift_q[6:0], sda};
                end
                if (last && (state_q == ST_ADDR || state_q == ST_DATA)) begin
                    bit_q <= bit_q - 3'd1;
                    if (state_q == ST_ADDR && bit_q == 3'd0)
                        shift_q <= data_q;
                    else if (!(state_q == ST_DATA && rw_q))
                        shift_q <= {shift_q[6:0], 1'b0};
                    if (state_q == ST_DATA && rw_q && bit_q == 3'd0)
                        data_rd_q <= shift_q;
                end
            end
        end
    end

    assign scl       = scl_low ? 1'b0 : 1'bz;
    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign busy      = (state_q != ST_IDLE);
    assign ack_error = ack_err_q;
    assign data_rd   = data_rd_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// tb/tb_i2c_master_core.sv - randomized bench for i2c_master_core with a bus-level slave model
module tb_i2c_master_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] data_wr = '0;
    logic       fast_mode = 1'b0;
    wire        busy, ack_error;
    wire  [7:0] data_rd;
    wire        scl, sda;

    pullup (scl);
    pullup (sda);

    logic slv_scl_low = 1'b0;
    logic slv_sda_low = 1'b0;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;
    assign sda = slv_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_core dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .addr      (addr),
        .rw        (rw),
        .data_wr   (data_wr),
        .fast_mode (fast_mode),
        .busy      (busy),
        .ack_error (ack_error),
        .data_rd   (data_rd),
        .scl       (scl),
        .sda       (sda)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave configuration (written only by the stimulus process)
    logic       slv_en = 1'b0;
    logic [6:0] slv_addr = '0;
    logic [7:0] slv_byte = '0;
    logic       slv_data_nack = 1'b0;
    logic       stretch_en = 1'b0;
    int         stretch_len = 0;

    // slave observations (written only by the slave process)
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    int         fall_cnt = 0, rise_cnt = 0, n_start = 0, n_stop = 0, hold_cnt = 0;
    logic [7:0] rx_addr = '0, rx_data = '0;
    logic       rx_ack1 = 1'b0, rx_ack2 = 1'b0, acked = 1'b0, rd_mode = 1'b0;

    always @(negedge clk) begin : slave_model
        logic s_scl, s_sda;
        int   k, r;
        s_scl = scl;
        s_sda = sda;
        if (!rst) begin
            slv_sda_low = 1'b0;
            slv_scl_low = 1'b0;
            hold_cnt    = 0;
        end else begin
            if (s_scl && scl_prev && sda_prev && !s_sda) begin
                n_start++;
                fall_cnt = 0;
                rise_cnt = 0;
            end
            if (s_scl && scl_prev && !sda_prev && s_sda) n_stop++;
            if (s_scl && !scl_prev) begin
                rise_cnt++;
                r = rise_cnt - 1;
                if (r < 8)       rx_addr = {rx_addr[6:0], s_sda};
                else if (r == 8) rx_ack1 = s_sda;
                else if (r < 17) rx_data = {rx_data[6:0], s_sda};
                else if (r == 17) rx_ack2 = s_sda;
            end
            if (!s_scl && scl_prev) begin
                fall_cnt++;
                k = fall_cnt - 1;
                if (k == 8) begin
                    acked       = slv_en && (rx_addr[7:1] == slv_addr);
                    rd_mode     = rx_addr[0];
                    slv_sda_low = acked;
                end else if (k >= 9 && k <= 16) begin
                    slv_sda_low = acked && rd_mode && !slv_byte[16-k];
                end else if (k == 17) begin
                    slv_sda_low = acked && !rd_mode && !slv_data_nack;
                end else begin
                    slv_sda_low = 1'b0;
                end
                if (stretch_en && fall_cnt == 14) begin
                    slv_scl_low = 1'b1;
                    hold_cnt    = stretch_len;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) slv_scl_low = 1'b0;
            end
        end
        scl_prev = s_scl;
        sda_prev = s_sda;
    end

    logic [7:0] model_rd = '0;

    task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_data,
                           input logic t_fast, input logic present, input logic [7:0] s_byte,
                           input logic d_nack, input logic stretch, input logic hold_en,
                           input logic pulse_mid, input string tag);
        int q, exp_busy, lat, cnt, st0, sp0;
        logic exp_err;
        logic [7:0] exp_rd;
        q        = 100_000_000 / (4 * (t_fast ? 400_000 : 100_000));
        exp_err  = !present || (!t_rw && d_nack);
        exp_busy = present ? (80 * q + (stretch ? 1000 : 0)) : 44 * q;
        exp_rd   = (present && t_rw) ? s_byte : model_rd;

        enable = 1'b0;
        repeat (3) @(negedge clk);
        slv_en = present; slv_addr = t_addr; slv_byte = s_byte; slv_data_nack = d_nack;
        stretch_en = stretch; stretch_len = 2 * q + 1000;
        st0 = n_start; sp0 = n_stop;
        addr = t_addr; rw = t_rw; data_wr = t_data; fast_mode = t_fast;
        enable = 1'b1;
        lat = 0;
        while (busy !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_start_latency"}, lat, 2);
        check({tag, "_ack_err_cleared"}, 32'(ack_error), 0);
        addr = 7'($urandom); data_wr = 8'($urandom); rw = 1'($urandom); fast_mode = 1'($urandom);
        if (!hold_en) enable = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40000) begin
            cnt++;
            if (pulse_mid && cnt == 100) enable = 1'b1;
            if (pulse_mid && cnt == 110) enable = 1'b0;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cnt, exp_busy);
        check({tag, "_ack_error"}, 32'(ack_error), 32'(exp_err));
        check({tag, "_data_rd"}, 32'(data_rd), 32'(exp_rd));
        check({tag, "_starts"}, n_start - st0, 1);
        check({tag, "_stops"}, n_stop - sp0, 1);
        check({tag, "_addr_byte"}, 32'(rx_addr), 32'({t_addr, t_rw}));
        check({tag, "_addr_ack"}, 32'(rx_ack1), 32'(!present));
        if (present) begin
            check({tag, "_scl_rises"}, rise_cnt, 19);
            check({tag, "_data_byte"}, 32'(rx_data), t_rw ? 32'(s_byte) : 32'(t_data));
            check({tag, "_data_ack"}, 32'(rx_ack2), t_rw ? 1 : 32'(d_nack));
        end else begin
            check({tag, "_scl_rises"}, rise_cnt, 10);
        end
        model_rd = exp_rd;
    endtask

    task automatic watch_idle(input string tag);
        int seen;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int lat;
        repeat (4) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_ack_error", 32'(ack_error), 0);
        check("reset_data_rd", 32'(data_rd), 0);
        check("reset_scl", 32'(scl), 1);
        check("reset_sda", 32'(sda), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1'b0, 7'h50, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "wr_std");
        run_txn(1'b1, 7'h48, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "rd_fast");
        run_txn(1'b0, 7'h21, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "addr_nack");
        run_txn(1'b0, 7'h2A, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "stretch");
        run_txn(1'b0, 7'h11, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "data_nack");
        run_txn(1'b1, 7'h35, 8'h00, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, "held_en");
        watch_idle("held_en_no_retrigger");
        run_txn(1'b0, 7'h62, 8'h18, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "pulse_busy");
        watch_idle("pulse_busy_no_retrigger");

        for (int i = 0; i < 4; i++)
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), 1'b1, ($urandom_range(0, 3) != 0),
                    8'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0, "rand");

        enable = 1'b0;
        repeat (3) @(negedge clk);
        slv_en = 1'b1; slv_addr = 7'h33; stretch_en = 1'b0; slv_data_nack = 1'b0;
        addr = 7'h33; rw = 1'b0; data_wr = 8'h5A; fast_mode = 1'b1;
        enable = 1'b1;
        lat = 0;
        while (busy !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("rst_mid_started", 32'(busy), 1);
        repeat (50 * 62) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_scl", 32'(scl), 1);
        check("rst_mid_sda", 32'(sda), 1);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_data_rd", 32'(data_rd), 0);
        model_rd = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        run_txn(1'b1, 7'h4D, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
